// File: rtl/prog_sequencer.sv
// Batch run controller for the 9-bit-instruction core: init hold, per-program req/ack, cycle timing, watchdog.
// Optional `SEQ_PERF_LOG_EN adds a saturating batch cycle accumulator on total_cycles.
module prog_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int PIDX_W      = 2,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT     = 4000,
    parameter int INIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                init_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                core_init,
    output logic                core_req,
    input  logic                core_ack,
    output logic [PIDX_W-1:0]   prog_idx,
    output logic [CYC_W-1:0]    cycle_count,
    output logic                cycle_valid,
    output logic                timeout_err,
    output logic [CYC_W+3:0]    total_cycles
);

    localparam int ICNT_W = $clog2(INIT_CYCLES) + 1;
    localparam logic [CYC_W-1:0]  TIMEOUT_C   = CYC_W'(TIMEOUT);
    localparam logic [ICNT_W-1:0] INIT_LAST   = ICNT_W'(INIT_CYCLES - 1);
    localparam logic [PIDX_W-1:0] LAST_PROG   = PIDX_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_REQ, S_ARM, S_RUN, S_REPORT, S_FIN
    } state_t;

    state_t             state, nxt;
    logic [ICNT_W-1:0]  init_cnt;
    logic [CYC_W-1:0]   cnt;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Every status output is a pure decode of the state register.
    assign busy        = (state != S_IDLE);
    assign core_init   = (state == S_INIT);
    assign core_req    = (state == S_REQ);
    assign cycle_valid = (state == S_REPORT);
    assign done        = (state == S_FIN);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start) nxt = S_INIT;
            S_INIT:   if (init_cnt == INIT_LAST) nxt = S_REQ;
            S_REQ:    nxt = S_ARM;
            S_ARM:    nxt = S_RUN;
            S_RUN: begin
                if (core_ack)               nxt = S_REPORT;
                else if (cnt == TIMEOUT_C)  nxt = S_FIN;
            end
            S_REPORT: nxt = (prog_idx == LAST_PROG) ? S_FIN : S_REQ;
            S_FIN:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            init_cnt    <= '0;
            cnt         <= '0;
            prog_idx    <= '0;
            cycle_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        init_cnt    <= '0;
                        prog_idx    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_INIT: init_cnt <= init_cnt + 1'b1;
                S_REQ:  cnt <= '0;
                // Ack seen here is the previous program's halt, so it is not sampled.
                S_ARM:  cnt <= sat_inc(cnt);
                S_RUN: begin
                    if (core_ack)              cycle_count <= cnt;
                    else if (cnt == TIMEOUT_C) timeout_err <= 1'b1;
                    else                       cnt <= sat_inc(cnt);
                end
                S_REPORT: if (prog_idx != LAST_PROG) prog_idx <= prog_idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_LOG_EN
    logic [CYC_W+3:0] total_q;

    function automatic logic [CYC_W+3:0] sat_acc(input logic [CYC_W+3:0] acc,
                                                 input logic [CYC_W-1:0] add);
        logic [CYC_W+4:0] sum;
        sum = {1'b0, acc} + {5'b0, add};
        return sum[CYC_W+4] ? {(CYC_W+4){1'b1}} : sum[CYC_W+3:0];
    endfunction

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n)                         total_q <= '0;
        else if (state == S_IDLE && start)   total_q <= '0;
        else if (state == S_REPORT)          total_q <= sat_acc(total_q, cycle_count);
    end

    assign total_cycles = total_q;
`else
    assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: main DUT (TIMEOUT=4000) plus a watchdog DUT (TIMEOUT=20, ack stuck low).
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ack = 1'b0;
    logic        ack2 = 1'b0;
    logic        busy, done, core_init, core_req, cycle_valid, timeout_err;
    logic [1:0]  prog_idx;
    logic [15:0] cycle_count;
    logic [19:0] total_cycles;
    logic        busy2, done2, core_init2, core_req2, cycle_valid2, timeout_err2;
    logic [1:0]  prog_idx2;
    logic [15:0] cycle_count2;
    logic [19:0] total_cycles2;

    int checks = 0;
    int errors = 0;

    // Responder / monitor state
    int mode = 0;                 // 0: delay table, 1: ack held high
    int dly [3] = '{10, 3, 50};
    int exp_cnt [3] = '{9, 2, 49};
    int req_i = 0, wcnt = 0, kdel = 0;
    bit armed = 0;
    int n_init = 0, n_req = 0, n_val = 0, n_done = 0;
    int n_req2 = 0, n_val2 = 0;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk(clk), .init_n(init_n), .start(start), .busy(busy), .done(done),
        .core_init(core_init), .core_req(core_req), .core_ack(ack),
        .prog_idx(prog_idx), .cycle_count(cycle_count), .cycle_valid(cycle_valid),
        .timeout_err(timeout_err), .total_cycles(total_cycles)
    );

    prog_sequencer #(.TIMEOUT(20)) dut_wd (
        .clk(clk), .init_n(init_n), .start(start2), .busy(busy2), .done(done2),
        .core_init(core_init2), .core_req(core_req2), .core_ack(ack2),
        .prog_idx(prog_idx2), .cycle_count(cycle_count2), .cycle_valid(cycle_valid2),
        .timeout_err(timeout_err2), .total_cycles(total_cycles2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_total(input int v);
`ifdef SEQ_PERF_LOG_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Core model and event monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!init_n) begin
            ack = 1'b0;
            armed = 0;
        end else begin
            if (core_init) req_i = 0;
            if (core_req) begin
                ack   = (mode == 1);
                armed = (mode == 0);
                wcnt  = 0;
                kdel  = dly[req_i < 3 ? req_i : 2];
                req_i++;
            end else if (mode == 1) begin
                ack = 1'b1;
            end else if (armed) begin
                wcnt++;
                if (wcnt == kdel) begin
                    ack = 1'b1;
                    armed = 0;
                end
            end
            if (core_init) n_init++;
            if (core_req)  n_req++;
            if (done)      n_done++;
            if (core_init || core_req) chk("init_req_exclusive", core_init & core_req, 0);
            if (cycle_valid) begin
                chk("report_idx", prog_idx, n_val % 3);
                chk("report_cnt", cycle_count, exp_cnt[n_val % 3]);
                n_val++;
            end
            if (core_req2)    n_req2++;
            if (cycle_valid2) n_val2++;
        end
    end

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("init_after_start", core_init, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        bit prev_v = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
            prev_v = cycle_valid;
        end
        chk("done_seen", seen, 1);
        chk("done_after_report", prev_v, 1);
    endtask

    task automatic run_batch(input string name, input int m, input int tot, input bit mid_start);
        int b_init, b_req, b_val;
        mode = m;
        b_init = n_init; b_req = n_req; b_val = n_val;
        pulse_start();
        if (mid_start) begin
            repeat (5) @(negedge clk);
            #1 start = 1'b1;
            @(negedge clk); #1 start = 1'b0;
        end
        wait_done(600);
        chk({name, "_total"}, total_cycles, exp_total(tot));
        chk({name, "_to_err"}, timeout_err, 0);
        @(negedge clk); #1;
        chk({name, "_init_cycles"}, n_init - b_init, 2);
        chk({name, "_reqs"}, n_req - b_req, 3);
        chk({name, "_reports"}, n_val - b_val, 3);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idx_hold"}, prog_idx, 2);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_core_init"}, core_init, 0);
        chk({name, "_core_req"}, core_req, 0);
        chk({name, "_prog_idx"}, prog_idx, 0);
        chk({name, "_cycle_count"}, cycle_count, 0);
        chk({name, "_cycle_valid"}, cycle_valid, 0);
        chk({name, "_timeout_err"}, timeout_err, 0);
        chk({name, "_total"}, total_cycles, 0);
    endtask

    initial begin
        int b_done;
        bit seen;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1 init_n = 1'b1;

        // Normal batch with ack delays 10, 3, 50
        dly = '{10, 3, 50}; exp_cnt = '{9, 2, 49};
        run_batch("batch", 0, 60, 0);

        // Ack held high: stale ack ignored in ARM, seen in first RUN cycle
        exp_cnt = '{1, 1, 1};
        run_batch("ackhigh", 1, 3, 0);
        mode = 0;

        // Start pulsed during RUN of program 0 is ignored
        dly = '{10, 3, 50}; exp_cnt = '{9, 2, 49};
        run_batch("midstart", 0, 60, 1);

        // Watchdog instance: ack stuck low, TIMEOUT=20
        @(negedge clk); #1 start2 = 1'b1;
        @(negedge clk); #1 start2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (done2) begin seen = 1; break; end
        end
        chk("wd_done_seen", seen, 1);
        chk("wd_timeout_err", timeout_err2, 1);
        chk("wd_no_report", n_val2, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("wd_single_req", n_req2, 1);
        chk("wd_err_sticky", timeout_err2, 1);
        chk("wd_idle", busy2, 0);
        start2 = 1'b1;
        @(negedge clk); #1 start2 = 1'b0;
        chk("wd_err_cleared", timeout_err2, 0);

        // Asynchronous reset mid-RUN of program 1
        dly = '{10, 30, 50}; exp_cnt = '{9, 29, 49};
        mode = 0;
        b_done = n_done;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (core_req && prog_idx == 1) begin seen = 1; break; end
        end
        chk("rst_reached_prog1", seen, 1);
        repeat (4) @(negedge clk);
        #2 init_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        #1 chk("midreset_no_done", n_done - b_done, 0);
        init_n = 1'b1;
        n_val = 0;
        dly = '{10, 3, 50}; exp_cnt = '{9, 2, 49};
        run_batch("restart", 0, 60, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
